// File: rtl/pot_adc_pkg.sv
// Shared types and constants for the MCP3008-style SPI ADC reader.
package pot_adc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    DONE
  } state_t;

  localparam logic [4:0] FRAME_BITS   = 5'd17;
  localparam logic [4:0] CMD_BITS     = 5'd5;
  localparam logic [4:0] NULL_IDX     = 5'd6;
  localparam logic [4:0] DATA_MSB_IDX = 5'd7;
  localparam int         RAW_W        = 10;
  localparam int         AVG_DEPTH    = 4;

  // Command word on MOSI: start, single-ended, then channel MSB first; zero afterwards.
  function automatic logic cmd_bit(input logic [4:0] k, input logic [2:0] ch);
    logic b;
    b = 1'b0;
    if (k < CMD_BITS) begin
      case (k)
        5'd0, 5'd1: b = 1'b1;
        5'd2:       b = ch[2];
        5'd3:       b = ch[1];
        5'd4:       b = ch[0];
        default:    b = 1'b0;
      endcase
    end
    return b;
  endfunction

endpackage

// File: rtl/pot_adc_spi_reader_if.sv
// SPI pins between the reader (master) and the ADC (slave).
interface pot_adc_spi_reader_if;
  logic adc_cs_n;
  logic adc_sclk;
  logic adc_mosi;
  logic adc_miso;

  modport master (output adc_cs_n, output adc_sclk, output adc_mosi, input adc_miso);
  modport slave  (input adc_cs_n, input adc_sclk, input adc_mosi, output adc_miso);
endinterface

// File: rtl/pot_adc_tick_gen.sv
// Divider that pulses tick for one cycle every DIV enabled cycles; counter clears while en=0.
module pot_adc_tick_gen #(
  parameter int DIV = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  output logic tick
);
  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset || !en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = en && (cnt == LAST);
endmodule

// File: rtl/pot_adc_spi_reader.sv
// MCP3008-style SPI ADC reader (mode 0 master) delivering pot_value with a valid strobe.
// Define POT_ADC_AVG_EN to output the average of the last four conversions on pot_value.
module pot_adc_spi_reader
  import pot_adc_pkg::*;
#(
  parameter int CLK_HZ    = 27_000_000,
  parameter int SCLK_HZ   = 1_000_000,
  parameter int SAMPLE_HZ = 1_000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [2:0]           channel,
  pot_adc_spi_reader_if.master spi,
  output logic [RAW_W-1:0]     raw_value,
  output logic [7:0]           pot_value,
  output logic                 valid,
  output logic                 busy,
  output logic                 null_err,
  output state_t               state_dbg
);
  // HALF must stay >= 3 so the 2-flop MISO synchronizer settles within a low phase.
  localparam int HALF_CALC  = CLK_HZ / (2 * SCLK_HZ);
  localparam int HALF       = (HALF_CALC < 1) ? 1 : HALF_CALC;
  localparam int SAMPLE_DIV = CLK_HZ / SAMPLE_HZ;

  state_t           state, state_next;
  logic             sample_tick, half_tick, half_en;
  logic             start_frame, enter_shift, rise, fall, finish;
  logic             cs_n_q, sclk_q, mosi_q;
  logic [2:0]       ch_q;
  logic [4:0]       k;
  logic             phase;
  logic             guard_ok;
  logic             miso_s1, miso_s2;
  logic [RAW_W-1:0] shreg;
  logic [7:0]       pot_next;

  pot_adc_tick_gen #(.DIV(SAMPLE_DIV)) u_sample_tick (
    .clock(clock), .reset(reset), .en(enable), .tick(sample_tick)
  );

  pot_adc_tick_gen #(.DIV(HALF)) u_half_tick (
    .clock(clock), .reset(reset), .en(half_en), .tick(half_tick)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Every timed state leaves on half_tick, so the half counter is back at 0 on each entry.
  always_comb begin
    state_next  = state;
    half_en     = 1'b0;
    start_frame = 1'b0;
    enter_shift = 1'b0;
    rise        = 1'b0;
    fall        = 1'b0;
    finish      = 1'b0;
    case (state)
      IDLE: begin
        half_en = !guard_ok;
        if (sample_tick && guard_ok) begin
          start_frame = 1'b1;
          state_next  = SETUP;
        end
      end
      SETUP: begin
        half_en = 1'b1;
        if (half_tick) begin
          enter_shift = 1'b1;
          state_next  = SHIFT;
        end
      end
      SHIFT: begin
        half_en = 1'b1;
        if (half_tick) begin
          if (!phase) begin
            rise = 1'b1;
          end else begin
            fall = 1'b1;
            if (k == (FRAME_BITS - 5'd1)) state_next = HOLD;
          end
        end
      end
      HOLD: begin
        half_en = 1'b1;
        if (half_tick) state_next = DONE;
      end
      DONE: begin
        finish     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef POT_ADC_AVG_EN
  // The three previous conversions; the fourth sample of the average is shreg itself.
  logic [RAW_W-1:0] hist [AVG_DEPTH-1];
  logic [RAW_W+1:0] avg_sum;

  always_comb begin
    avg_sum = (RAW_W + 2)'(shreg);
    for (int i = 0; i < AVG_DEPTH - 1; i++) avg_sum = avg_sum + (RAW_W + 2)'(hist[i]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < AVG_DEPTH - 1; i++) hist[i] <= '0;
    end else if (finish) begin
      hist[0] <= shreg;
      for (int i = 1; i < AVG_DEPTH - 1; i++) hist[i] <= hist[i-1];
    end
  end

  assign pot_next = avg_sum[RAW_W+1:4];
`else
  assign pot_next = shreg[RAW_W-1:2];
`endif

  // valid is a one-cycle strobe with no ready: raw_value/pot_value change in that cycle
  // and hold until the next strobe, so the consumer never needs to acknowledge.
  always_ff @(posedge clock) begin
    if (reset) begin
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      ch_q      <= '0;
      k         <= '0;
      phase     <= 1'b0;
      guard_ok  <= 1'b1;
      miso_s1   <= 1'b0;
      miso_s2   <= 1'b0;
      shreg     <= '0;
      raw_value <= '0;
      pot_value <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      null_err  <= 1'b0;
    end else begin
      miso_s1 <= spi.adc_miso;
      miso_s2 <= miso_s1;
      valid   <= 1'b0;
      if (state == IDLE && half_tick) guard_ok <= 1'b1;
      if (start_frame) begin
        ch_q   <= channel;
        cs_n_q <= 1'b0;
        busy   <= 1'b1;
        shreg  <= '0;
      end
      if (enter_shift) begin
        k      <= '0;
        phase  <= 1'b0;
        mosi_q <= cmd_bit(5'd0, ch_q);
      end
      if (rise) begin
        sclk_q <= 1'b1;
        phase  <= 1'b1;
        if (k == NULL_IDX && miso_s2) null_err <= 1'b1;
        if (k >= DATA_MSB_IDX) shreg <= {shreg[RAW_W-2:0], miso_s2};
      end
      if (fall) begin
        sclk_q <= 1'b0;
        phase  <= 1'b0;
        k      <= k + 5'd1;
        mosi_q <= cmd_bit(k + 5'd1, ch_q);
      end
      if (finish) begin
        cs_n_q    <= 1'b1;
        busy      <= 1'b0;
        valid     <= 1'b1;
        raw_value <= shreg;
        pot_value <= pot_next;
        guard_ok  <= 1'b0;
      end
    end
  end

  assign spi.adc_cs_n = cs_n_q;
  assign spi.adc_sclk = sclk_q;
  assign spi.adc_mosi = mosi_q;
  assign state_dbg    = state;
endmodule

// File: tb/tb_pot_adc_spi_reader.sv
// Directed bench for pot_adc_spi_reader with a behavioural MCP3008 on the SPI pins.
module tb_pot_adc_spi_reader;
  import pot_adc_pkg::*;

  localparam int CLK_HZ       = 27_000_000;
  localparam int SCLK_HZ      = 1_000_000;
  localparam int SAMPLE_HZ    = 10_000;
  localparam int SAMPLE_DIV   = 2700;
  localparam int FRAME_CYCLES = 469;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic [2:0] channel;
  logic [9:0] raw_value;
  logic [7:0] pot_value;
  logic       valid, busy, null_err;
  state_t     state_dbg;

  pot_adc_spi_reader_if spi ();

  pot_adc_spi_reader #(.CLK_HZ(CLK_HZ), .SCLK_HZ(SCLK_HZ), .SAMPLE_HZ(SAMPLE_HZ)) dut (
    .clock(clock), .reset(reset), .enable(enable), .channel(channel), .spi(spi),
    .raw_value(raw_value), .pot_value(pot_value), .valid(valid), .busy(busy),
    .null_err(null_err), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int fails  = 0;

  // ADC model state
  logic [9:0] m_data = '0;
  logic       m_null = 1'b0;
  logic       m_err_exp = 1'b0;
  int         m_rise = 0;
  int         m_cs_cnt = 0;
  int         m_cs_len = 0;
  logic [4:0] m_cmd = '0;
  logic [4:0] m_cmd_frame = '0;
  logic       m_cs_q = 1'b1;
  logic       m_sclk_q = 1'b0;
  logic [9:0] m_hist [3];

  always @(negedge clock) begin
    if (spi.adc_cs_n === 1'b0) begin
      if (m_cs_cnt == 0) m_cmd_frame = '0;
      m_cs_cnt++;
      if (spi.adc_sclk === 1'b1 && m_sclk_q === 1'b0) begin
        if (m_rise < 5) m_cmd = {m_cmd[3:0], spi.adc_mosi};
        m_rise++;
        if (m_rise == 5) m_cmd_frame = m_cmd;
      end else if (spi.adc_sclk === 1'b0 && m_sclk_q === 1'b1) begin
        if (m_rise == 6) spi.adc_miso = m_null;
        else if (m_rise >= 7 && m_rise <= 16) spi.adc_miso = m_data[16 - m_rise];
        else spi.adc_miso = 1'b0;
      end
    end else begin
      if (m_cs_q === 1'b0) m_cs_len = m_cs_cnt;
      m_cs_cnt = 0;
      m_rise   = 0;
      m_cmd    = '0;
      spi.adc_miso = 1'b0;
    end
    m_cs_q   = spi.adc_cs_n;
    m_sclk_q = spi.adc_sclk;
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic clear_hist();
    foreach (m_hist[i]) m_hist[i] = '0;
  endtask

  // Expected pot_value for a completed frame; the averaging build keeps its own history.
  task automatic expect_pot(input logic [9:0] data, input logic [7:0] plain, output logic [7:0] pot_exp);
`ifdef POT_ADC_AVG_EN
    logic [11:0] sum;
    sum = 12'(data) + 12'(m_hist[0]) + 12'(m_hist[1]) + 12'(m_hist[2]);
    pot_exp   = sum[11:4];
    m_hist[2] = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = data;
`else
    pot_exp = plain;
    if (data === 10'h3FF) pot_exp = plain;
`endif
  endtask

  task automatic run_frame(input string name, input logic [9:0] data, input logic nb,
                           input logic [2:0] ch, input logic [7:0] pot_plain);
    int n;
    logic [7:0] pot_exp;
    m_data  = data;
    m_null  = nb;
    channel = ch;
    n = 0;
    while (spi.adc_cs_n !== 1'b0 && n < SAMPLE_DIV + FRAME_CYCLES + 50) begin step(); n++; end
    checks++;
    if (spi.adc_cs_n !== 1'b0) begin
      fails++; $display("FAIL %s_start: cs_n=%b after %0d cycles, want 0", name, spi.adc_cs_n, n); return;
    end
    checks++;
    if (busy !== 1'b1) begin fails++; $display("FAIL %s_busy: got %b want 1", name, busy); end
    n = 0;
    while (valid !== 1'b1 && n < FRAME_CYCLES + 50) begin step(); n++; end
    checks++;
    if (valid !== 1'b1) begin
      fails++; $display("FAIL %s_valid: no valid within %0d cycles", name, n); return;
    end
    if (nb) m_err_exp = 1'b1;
    expect_pot(data, pot_plain, pot_exp);
    checks++;
    if (raw_value !== data) begin fails++; $display("FAIL %s_raw: got %h want %h", name, raw_value, data); end
    checks++;
    if (pot_value !== pot_exp) begin fails++; $display("FAIL %s_pot: got %h want %h", name, pot_value, pot_exp); end
    checks++;
    if (spi.adc_cs_n !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL %s_end: cs_n=%b busy=%b want 1,0", name, spi.adc_cs_n, busy);
    end
    checks++;
    if (m_cs_len != FRAME_CYCLES) begin fails++; $display("FAIL %s_cs_len: got %0d want %0d", name, m_cs_len, FRAME_CYCLES); end
    checks++;
    if (m_cmd_frame !== {2'b11, ch}) begin fails++; $display("FAIL %s_mosi: got %b want %b", name, m_cmd_frame, {2'b11, ch}); end
    checks++;
    if (null_err !== m_err_exp) begin fails++; $display("FAIL %s_null_err: got %b want %b", name, null_err, m_err_exp); end
    step();
    checks++;
    if (valid !== 1'b0) begin fails++; $display("FAIL %s_valid_width: got %b want 0", name, valid); end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; channel = 3'd0;
    clear_hist();
    repeat (3) step();
    checks++; if (spi.adc_cs_n !== 1'b1) begin fails++; $display("FAIL reset_cs_n: got %b want 1", spi.adc_cs_n); end
    checks++; if (spi.adc_sclk !== 1'b0) begin fails++; $display("FAIL reset_sclk: got %b want 0", spi.adc_sclk); end
    checks++; if (spi.adc_mosi !== 1'b0) begin fails++; $display("FAIL reset_mosi: got %b want 0", spi.adc_mosi); end
    checks++; if (raw_value !== 10'h0) begin fails++; $display("FAIL reset_raw: got %h want 000", raw_value); end
    checks++; if (pot_value !== 8'h0) begin fails++; $display("FAIL reset_pot: got %h want 00", pot_value); end
    checks++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (null_err !== 1'b0) begin fails++; $display("FAIL reset_null_err: got %b want 0", null_err); end
    checks++; if (state_dbg !== IDLE) begin fails++; $display("FAIL reset_state: got %0d want IDLE", state_dbg); end
    reset = 1'b0;
    m_err_exp = 1'b0;
  endtask

  task automatic test_basic();
    enable = 1'b1;
    run_frame("basic", 10'h2A5, 1'b0, 3'd3, 8'hA9);
  endtask

  task automatic test_full_scale();
    run_frame("full", 10'h3FF, 1'b0, 3'd0, 8'hFF);
    run_frame("zero", 10'h000, 1'b0, 3'd7, 8'h00);
  endtask

  task automatic test_null_bit();
    run_frame("null", 10'h1F0, 1'b1, 3'd1, 8'h7C);
    run_frame("after_null", 10'h2C8, 1'b0, 3'd6, 8'hB2);
  endtask

  task automatic test_reset_mid_frame();
    int n;
    int vseen;
    m_data = 10'h155; m_null = 1'b0; channel = 3'd2;
    n = 0;
    while (!(m_rise == 9 && spi.adc_sclk === 1'b0) && n < SAMPLE_DIV + FRAME_CYCLES) begin step(); n++; end
    checks++;
    if (m_rise != 9) begin fails++; $display("FAIL midreset_reach: rise=%0d want 9", m_rise); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    clear_hist();
    m_err_exp = 1'b0;
    checks++;
    if (spi.adc_cs_n !== 1'b1 || spi.adc_sclk !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL midreset_pins: cs_n=%b sclk=%b busy=%b want 1,0,0", spi.adc_cs_n, spi.adc_sclk, busy);
    end
    checks++;
    if (null_err !== 1'b0) begin fails++; $display("FAIL midreset_null_err: got %b want 0", null_err); end
    vseen = 0;
    for (int i = 0; i < 300; i++) begin
      if (valid === 1'b1) vseen++;
      step();
    end
    checks++;
    if (vseen != 0) begin fails++; $display("FAIL midreset_valid: %0d pulses want 0", vseen); end
    checks++;
    if (raw_value !== 10'h0) begin fails++; $display("FAIL midreset_raw: got %h want 000", raw_value); end
  endtask

  task automatic test_enable_gap();
    int n;
    int lows;
    logic [7:0] pot_exp;
    enable = 1'b0;
    lows = 0;
    for (int i = 0; i < 5 * SAMPLE_DIV; i++) begin
      step();
      if (spi.adc_cs_n !== 1'b1) lows++;
    end
    checks++;
    if (lows != 0) begin fails++; $display("FAIL gap_cs_activity: %0d low cycles want 0", lows); end
    channel = 3'd5; m_data = 10'h0C3; m_null = 1'b0;
    enable = 1'b1;
    n = 0;
    while (spi.adc_cs_n !== 1'b0 && n < SAMPLE_DIV + 100) begin step(); n++; end
    checks++;
    if (n != SAMPLE_DIV) begin fails++; $display("FAIL gap_first_frame: started after %0d want %0d", n, SAMPLE_DIV); end
    channel = 3'd2;
    n = 0;
    while (valid !== 1'b1 && n < FRAME_CYCLES + 50) begin step(); n++; end
    checks++;
    if (valid !== 1'b1) begin fails++; $display("FAIL gap_valid: no valid within %0d cycles", n); return; end
    expect_pot(10'h0C3, 8'h30, pot_exp);
    checks++;
    if (m_cmd_frame !== 5'b11101) begin fails++; $display("FAIL chan_latch_mosi: got %b want 11101", m_cmd_frame); end
    checks++;
    if (raw_value !== 10'h0C3 || pot_value !== pot_exp) begin
      fails++; $display("FAIL chan_latch_data: raw=%h pot=%h want 0c3,%h", raw_value, pot_value, pot_exp);
    end
    step();
  endtask

`ifdef POT_ADC_AVG_EN
  task automatic test_avg();
    logic [7:0] seq [4];
    seq[0] = 8'h3F; seq[1] = 8'h7F; seq[2] = 8'hBF; seq[3] = 8'hFF;
    reset = 1'b1; step(); reset = 1'b0;
    clear_hist();
    m_err_exp = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_frame("avg", 10'h3FF, 1'b0, 3'd4, 8'hFF);
      checks++;
      if (pot_value !== seq[i]) begin fails++; $display("FAIL avg_seq%0d: got %h want %h", i, pot_value, seq[i]); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_full_scale();
    test_null_bit();
    test_reset_mid_frame();
    test_enable_gap();
`ifdef POT_ADC_AVG_EN
    test_avg();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/pot_adc_spi_reader.md
Name: pot_adc_spi_reader

Overview:
- Replaces the key-switch stand-in for `pot_value` with a real potentiometer reading.
- Periodically reads an MCP3008-style 10-bit SPI ADC wired to the board gpio pins.
- Delivers an 8-bit `pot_value` plus a one-cycle `valid` strobe to the display logic (LEDs, 7-segment display, LCD bar).
- Acts as SPI master (mode 0, bit-banged from the system clock); the ADC is the responder.

Parameters:
- CLK_HZ, 27_000_000, system clock frequency.
- SCLK_HZ, 1_000_000, target SPI clock; HALF = CLK_HZ/(2*SCLK_HZ) integer-truncated, minimum 1.
- SAMPLE_HZ, 1_000, conversion rate; SAMPLE_DIV = CLK_HZ/SAMPLE_HZ.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = free-running conversions at SAMPLE_HZ.
- channel  in  3  ADC channel; latched at frame start.
- adc_cs_n  out  1  chip select, active low.
- adc_sclk  out  1  SPI clock, idles low.
- adc_mosi  out  1  command bits to the ADC.
- adc_miso  in  1  data from the ADC; double-flopped internally.
- raw_value  out  10  last complete 10-bit conversion.
- pot_value  out  8  raw_value[9:2] (or the averaged value, see Optional Feature).
- valid  out  1  one-cycle pulse when raw_value/pot_value update.
- busy  out  1  high while a frame is in progress.
- null_err  out  1  sticky; set when the null bit reads 1; cleared by reset only.

Behaviour:
- Reset values: adc_cs_n=1, adc_sclk=0, adc_mosi=0, raw_value=0, pot_value=0, valid=0, busy=0, null_err=0. State=IDLE; sample counter=0.
- Reset asserted mid-frame: on the next edge, CS is released and SCLK is forced low; the partial frame is discarded and valid stays 0.
- Sample tick:
  - A counter runs 0..SAMPLE_DIV-1 while enable=1 and pulses a tick on wrap.
  - With enable=0 the counter holds at 0.
  - A tick arriving while busy is dropped, not queued.
- States:
  - IDLE: on tick, latch channel, drive adc_cs_n=0, set busy=1, go to SETUP.
  - SETUP: wait HALF cycles (CS-to-first-edge setup), then go to SHIFT with k=0.
  - SHIFT: SCLK low for HALF cycles, then high for HALF cycles, for k=0..16 (17 periods). After the low phase of k=16 completes its high phase, go to HOLD.
  - HOLD: SCLK=0, wait HALF cycles, then go to DONE.
  - DONE: drive adc_cs_n=1, update outputs, pulse valid, clear busy, return to IDLE. At least HALF cycles of CS-high pass before the next frame, enforced in IDLE.
- Bit mapping:
  - MOSI changes at the start of each low phase.
  - MISO is sampled (synchronized value) on the cycle SCLK rises.
  - Period index k:
    - k=0: start bit, MOSI=1.
    - k=1: SGL/DIFF, MOSI=1.
    - k=2..4: channel[2:0], MSB first.
    - k=5: sample period; MOSI=0, MISO ignored.
    - k=6: null bit; expected 0, a 1 sets null_err.
    - k=7..16: B9..B0, shifted MSB-first into a 10-bit register.
  - MOSI=0 for k≥5.
- The 2-flop MISO synchronizer adds 2 cycles of delay. This is legal because HALF≥3 at the defaults; HALF<3 is unsupported.
- Frame length: HALF*(1+34+1) cycles plus the DONE cycle. At the defaults (HALF=13) that is 469 cycles.
- valid latency: exactly 1 cycle after the DONE entry edge; raw_value and pot_value change in the same cycle valid=1.
- Width: pot_value = raw[9:2] (truncation, no rounding); full-scale 0x3FF gives 0xFF.

Optional Feature:
- Macro: POT_ADC_AVG_EN.
- Defined:
  - Keep the last 4 raw samples in a shift buffer.
  - pot_value = (sum of the 4 samples)>>4, using a 12-bit sum so 4*1023 fits.
  - The buffer is zero at reset, so the first 3 outputs ramp up from zero.
  - raw_value remains unfiltered.
  - valid timing is unchanged (the average is computed in the DONE cycle).
- Undefined: pot_value = raw[9:2], and no buffer logic is generated.

Decomposition:
- Package pot_adc_pkg holds:
  - state enum (IDLE, SETUP, SHIFT, HOLD, DONE);
  - constants FRAME_BITS=17, CMD_BITS=5, NULL_IDX=6, DATA_MSB_IDX=7, RAW_W=10, AVG_DEPTH=4.
- Sub-module pot_adc_tick_gen: a parameterised divider that outputs a one-cycle tick, with enable/hold semantics. It is instantiated twice: once for the sample tick and once for the HALF-period tick.

Test Plan (CLK_HZ=27M, SCLK_HZ=1M, SAMPLE_HZ=10k, behavioural MCP3008 model on the SPI pins):
- Model returns 0x2A5 on channel 3 -> MOSI bits observed 1,1,0,1,1; raw_value=0x2A5; pot_value=0xA9; one valid pulse; adc_cs_n low for 469 cycles.
- Model returns 0x3FF, then 0x000 -> pot_value 0xFF, then 0x00; null_err stays 0.
- Model drives null bit=1 -> null_err=1 and stays 1 through later clean frames until reset.
- Assert reset at k=9 of a frame -> next cycle adc_cs_n=1, adc_sclk=0, busy=0; no valid pulse; raw_value=0.
- enable=0 for 5 sample periods -> no CS activity; re-enable -> first frame starts exactly SAMPLE_DIV cycles later. Change channel mid-frame -> current frame keeps the old channel bits.
- POT_ADC_AVG_EN defined, samples 0x3FF×4 -> pot_value sequence 0x3F, 0x7F, 0xBF, 0xFF.
